// File: rtl/psync_seq.sv
`default_nettype none
// ============================================================================
//  Module      : psync_seq
//  Description : Phase-synchronous PLL sequencer. Synchronizes the system
//                sync reference into the CKVD domain, qualifies its edges,
//                clears the DTC/MMD phase accumulator, waits a settle window,
//                runs LO phase calibration and reports done / error.
//  Revision    : 1.0  initial release
// ============================================================================
module psync_seq #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ECNT_W      = 8
) (
  input  logic              CKVD,
  input  logic              NARST,
  input  logic              SYNC_EN,
  input  logic              SYNC_REF,
  input  logic [1:0]        EDGE_SEL,
  input  logic              RESYNC_EN,
  input  logic [CNT_W-1:0]  SETTLE_CYC,
  input  logic [CNT_W-1:0]  CAL_TIMEOUT,
  input  logic              FREQLOCK,
  input  logic              LO_PCALI_DONE,
  output logic              PACC_CLR,
  output logic              LO_PCALI_EN,
  output logic              SYNC_DONE,
  output logic              SYNC_ERR,
  output logic [2:0]        STATE,
  output logic [ECNT_W-1:0] EDGE_CNT
);

  // --------------------------------------------------------------------------
  // State encoding (code 7 is unused and recovers to IDLE)
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_CLR    = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_CAL    = 3'd4;
  localparam logic [2:0] S_LOCK   = 3'd5;
  localparam logic [2:0] S_FAIL   = 3'd6;

  localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ECNT_W-1:0] ECNT_MAX = '1;
  localparam logic [ECNT_W-1:0] ECNT_ONE = {{(ECNT_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Internal signals
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sync_last;
  logic                   edge_rise;
  logic                   edge_fall;
  logic                   edge_qual;

  logic [2:0]             state_q;
  logic [2:0]             state_d;

  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   cnt_is_one;

  logic [ECNT_W-1:0]      ecnt_q;
  logic [ECNT_W-1:0]      ecnt_d;

  logic                   pacc_clr_d;
  logic                   lo_pcali_en_d;
  logic                   sync_done_d;
  logic                   sync_err_d;

  // --------------------------------------------------------------------------
  // SYNC_REF synchronizer plus one history flop; runs regardless of FSM state
  // so the edge detector is already primed when the sequencer is enabled.
  // --------------------------------------------------------------------------
  always_ff @(posedge CKVD or negedge NARST) begin
    if (!NARST) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], SYNC_REF};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign edge_rise = sync_last & ~hist_q;
  assign edge_fall = ~sync_last & hist_q;

  // Qualify the detected transition according to the selected edge polarity.
  always_comb begin
    edge_qual = 1'b0;
    case (EDGE_SEL)
      2'b00:   edge_qual = edge_rise;
      2'b01:   edge_qual = edge_fall;
      default: edge_qual = edge_rise | edge_fall;
    endcase
  end

  assign cnt_is_one = (cnt_q == CNT_ONE);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CKVD or negedge NARST) begin
    if (!NARST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic; SYNC_EN low overrides everything, FAIL is sticky.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (!SYNC_EN) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ARM;
        end
        S_ARM: begin
          // An edge without frequency lock is only counted.
          if (edge_qual && FREQLOCK) begin
            state_d = S_CLR;
          end
        end
        S_CLR: begin
          // Zero settle time skips straight to calibration.
          if (SETTLE_CYC == CNT_ZERO) begin
            state_d = S_CAL;
          end else begin
            state_d = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!FREQLOCK) begin
            state_d = S_FAIL;
          end else if (cnt_q <= CNT_ONE) begin
            state_d = S_CAL;
          end
        end
        S_CAL: begin
          // Calibration completion beats both lock loss and timeout.
          if (LO_PCALI_DONE) begin
            state_d = S_LOCK;
          end else if (!FREQLOCK) begin
            state_d = S_FAIL;
          end else if (cnt_is_one) begin
            // A zero timeout loads zero and never decrements to one.
            state_d = S_FAIL;
          end
        end
        S_LOCK: begin
          if (!FREQLOCK) begin
            state_d = S_FAIL;
          end else if (edge_qual && RESYNC_EN) begin
            state_d = S_CLR;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM output decode, taken from the next state so the registered outputs
  // line up with the state register in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    pacc_clr_d    = (state_d == S_CLR);
    lo_pcali_en_d = (state_d == S_CAL);
    sync_done_d   = (state_d == S_LOCK);
    sync_err_d    = (state_d == S_FAIL);
  end

  // Registered outputs: flop-driven so PACC_CLR can never glitch.
  always_ff @(posedge CKVD or negedge NARST) begin
    if (!NARST) begin
      PACC_CLR    <= 1'b0;
      LO_PCALI_EN <= 1'b0;
      SYNC_DONE   <= 1'b0;
      SYNC_ERR    <= 1'b0;
    end else begin
      PACC_CLR    <= pacc_clr_d;
      LO_PCALI_EN <= lo_pcali_en_d;
      SYNC_DONE   <= sync_done_d;
      SYNC_ERR    <= sync_err_d;
    end
  end

  assign STATE = state_q;

  // --------------------------------------------------------------------------
  // Settle / timeout counter: config values are captured only when a window
  // begins, then the counter walks down and parks at zero.
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == S_IDLE) begin
      cnt_d = CNT_ZERO;
    end else if ((state_q == S_CLR) && (state_d == S_SETTLE)) begin
      cnt_d = SETTLE_CYC;
    end else if ((state_q != S_CAL) && (state_d == S_CAL)) begin
      cnt_d = CAL_TIMEOUT;
    end else if (((state_q == S_SETTLE) || (state_q == S_CAL)) &&
                 (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Counter register.
  always_ff @(posedge CKVD or negedge NARST) begin
    if (!NARST) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Qualified-edge counter: cleared while disabled, counts outside IDLE in
  // every state (including those that ignore the edge), saturates at max.
  // --------------------------------------------------------------------------
  always_comb begin
    ecnt_d = ecnt_q;
    if (!SYNC_EN) begin
      ecnt_d = '0;
    end else if (edge_qual && (state_q != S_IDLE) && (ecnt_q != ECNT_MAX)) begin
      ecnt_d = ecnt_q + ECNT_ONE;
    end
  end

  // Edge counter register.
  always_ff @(posedge CKVD or negedge NARST) begin
    if (!NARST) begin
      ecnt_q <= '0;
    end else begin
      ecnt_q <= ecnt_d;
    end
  end

  assign EDGE_CNT = ecnt_q;

endmodule
`default_nettype wire

// File: tb/tb_psync_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psync_seq
//  Description : Directed self-checking bench for psync_seq.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_psync_seq;

  logic        CKVD;
  logic        NARST;
  logic        SYNC_EN;
  logic        SYNC_REF;
  logic [1:0]  EDGE_SEL;
  logic        RESYNC_EN;
  logic [15:0] SETTLE_CYC;
  logic [15:0] CAL_TIMEOUT;
  logic        FREQLOCK;
  logic        LO_PCALI_DONE;
  logic        PACC_CLR;
  logic        LO_PCALI_EN;
  logic        SYNC_DONE;
  logic        SYNC_ERR;
  logic [2:0]  STATE;
  logic [7:0]  EDGE_CNT;

  int total = 0;
  int bad   = 0;

  psync_seq #(.CNT_W(16), .SYNC_STAGES(2), .ECNT_W(8)) dut (
    .CKVD          (CKVD),
    .NARST         (NARST),
    .SYNC_EN       (SYNC_EN),
    .SYNC_REF      (SYNC_REF),
    .EDGE_SEL      (EDGE_SEL),
    .RESYNC_EN     (RESYNC_EN),
    .SETTLE_CYC    (SETTLE_CYC),
    .CAL_TIMEOUT   (CAL_TIMEOUT),
    .FREQLOCK      (FREQLOCK),
    .LO_PCALI_DONE (LO_PCALI_DONE),
    .PACC_CLR      (PACC_CLR),
    .LO_PCALI_EN   (LO_PCALI_EN),
    .SYNC_DONE     (SYNC_DONE),
    .SYNC_ERR      (SYNC_ERR),
    .STATE         (STATE),
    .EDGE_CNT      (EDGE_CNT)
  );

  initial CKVD = 1'b0;
  always #5 CKVD = ~CKVD;

  task automatic tick(input int n);
    repeat (n) @(negedge CKVD);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // All four status outputs packed {PACC_CLR, LO_PCALI_EN, SYNC_DONE, SYNC_ERR}.
  function automatic logic [31:0] outs();
    return {28'd0, PACC_CLR, LO_PCALI_EN, SYNC_DONE, SYNC_ERR};
  endfunction

  initial begin
    NARST = 1'b0; SYNC_EN = 1'b0; SYNC_REF = 1'b0; EDGE_SEL = 2'b00;
    RESYNC_EN = 1'b0; SETTLE_CYC = 16'd10; CAL_TIMEOUT = 16'd0;
    FREQLOCK = 1'b1; LO_PCALI_DONE = 1'b0;

    // ---- reset state
    tick(3);
    check("rst_state", STATE, 0);
    check("rst_outs", outs(), 0);
    check("rst_ecnt", EDGE_CNT, 0);
    NARST = 1'b1;
    tick(2);

    // ---- 1: basic sequence, rising edge
    SYNC_EN = 1'b1;
    tick(1);
    check("t1_arm", STATE, 1);
    tick(2);
    SYNC_REF = 1'b1;
    tick(2);
    check("t1_pacc_early", PACC_CLR, 0);
    tick(1);
    check("t1_pacc", PACC_CLR, 1);
    check("t1_clr", STATE, 2);
    check("t1_ecnt", EDGE_CNT, 1);
    tick(1);
    check("t1_settle", STATE, 3);
    check("t1_pacc_1cyc", PACC_CLR, 0);
    tick(9);
    check("t1_settle_end", STATE, 3);
    check("t1_cal_early", LO_PCALI_EN, 0);
    tick(1);
    check("t1_cal", STATE, 4);
    check("t1_cal_en", LO_PCALI_EN, 1);
    tick(4);
    LO_PCALI_DONE = 1'b1;
    tick(1);
    LO_PCALI_DONE = 1'b0;
    check("t1_lock", STATE, 5);
    check("t1_lock_outs", outs(), 4'b0010);
    check("t1_lock_ecnt", EDGE_CNT, 1);

    // ---- 4: resync from LOCK on falling edge (both-edge select)
    RESYNC_EN = 1'b1; EDGE_SEL = 2'b10;
    SYNC_REF = 1'b0;
    tick(3);
    check("t4_clr", STATE, 2);
    check("t4_outs", outs(), 4'b1000);
    check("t4_ecnt", EDGE_CNT, 2);
    LO_PCALI_DONE = 1'b1;
    tick(12);
    LO_PCALI_DONE = 1'b0;
    check("t4_relock", STATE, 5);
    RESYNC_EN = 1'b0;
    SYNC_REF = 1'b1;
    tick(3);
    check("t4_noresync", STATE, 5);
    check("t4_noresync_outs", outs(), 4'b0010);
    check("t4_noresync_ecnt", EDGE_CNT, 3);

    // ---- 5a: lock loss in LOCK, FAIL sticky, disable returns to IDLE
    FREQLOCK = 1'b0;
    tick(1);
    check("t5_lock_fail", STATE, 6);
    check("t5_lock_fail_outs", outs(), 4'b0001);
    FREQLOCK = 1'b1;
    tick(2);
    check("t5_sticky", STATE, 6);
    SYNC_EN = 1'b0;
    tick(1);
    check("t5_idle", STATE, 0);
    check("t5_idle_outs", outs(), 0);
    check("t5_idle_ecnt", EDGE_CNT, 0);

    // ---- 2 + 5c: zero settle goes CLR->CAL, then 20-cycle cal timeout
    CAL_TIMEOUT = 16'd20; SETTLE_CYC = 16'd0; EDGE_SEL = 2'b00;
    SYNC_EN = 1'b1;
    tick(1);
    check("t2_arm", STATE, 1);
    SYNC_REF = 1'b0;
    tick(4);
    check("t2_fall_ignored", EDGE_CNT, 0);
    SYNC_REF = 1'b1;
    tick(3);
    check("t2_clr", STATE, 2);
    tick(1);
    check("t2_cal_direct", STATE, 4);
    check("t2_cal_en", LO_PCALI_EN, 1);
    tick(19);
    check("t2_cal_last", STATE, 4);
    tick(1);
    check("t2_timeout", STATE, 6);
    check("t2_timeout_outs", outs(), 4'b0001);
    SYNC_EN = 1'b0;
    tick(1);
    check("t2_idle", STATE, 0);
    check("t2_idle_outs", outs(), 0);

    // ---- 5b: lock loss during SETTLE
    SETTLE_CYC = 16'd10;
    SYNC_EN = 1'b1;
    tick(1);
    SYNC_REF = 1'b0;
    tick(3);
    SYNC_REF = 1'b1;
    tick(3);
    check("t5_clr", STATE, 2);
    tick(3);
    check("t5_settle", STATE, 3);
    FREQLOCK = 1'b0;
    tick(1);
    check("t5_settle_fail", STATE, 6);
    check("t5_settle_err", SYNC_ERR, 1);
    FREQLOCK = 1'b1;
    SYNC_EN = 1'b0;
    tick(1);

    // ---- 3: edges without FREQLOCK are only counted
    FREQLOCK = 1'b0;
    SYNC_EN = 1'b1;
    tick(1);
    check("t3_arm", STATE, 1);
    for (int i = 0; i < 3; i++) begin
      SYNC_REF = 1'b0;
      tick(3);
      SYNC_REF = 1'b1;
      tick(3);
      check("t3_no_pacc", PACC_CLR, 0);
    end
    check("t3_stay_arm", STATE, 1);
    check("t3_ecnt", EDGE_CNT, 3);
    FREQLOCK = 1'b1;
    SYNC_REF = 1'b0;
    tick(3);
    SYNC_REF = 1'b1;
    tick(3);
    check("t3_clr", STATE, 2);
    check("t3_pacc", PACC_CLR, 1);
    check("t3_ecnt2", EDGE_CNT, 4);

    // ---- 6: async reset during CAL, then edge counter saturation
    CAL_TIMEOUT = 16'd0;
    tick(12);
    check("t6_cal", STATE, 4);
    #1 NARST = 1'b0;
    #1;
    check("t6_async_state", STATE, 0);
    check("t6_async_outs", outs(), 0);
    check("t6_async_ecnt", EDGE_CNT, 0);
    SYNC_REF = 1'b0; FREQLOCK = 1'b0; EDGE_SEL = 2'b10;
    tick(2);
    NARST = 1'b1;
    tick(1);
    check("t6_arm", STATE, 1);
    check("t6_ecnt0", EDGE_CNT, 0);
    for (int i = 0; i < 100; i++) begin
      SYNC_REF = ~SYNC_REF;
      tick(1);
    end
    tick(3);
    check("t6_ecnt100", EDGE_CNT, 100);
    for (int i = 0; i < 200; i++) begin
      SYNC_REF = ~SYNC_REF;
      tick(1);
    end
    tick(3);
    check("t6_ecnt_sat", EDGE_CNT, 255);
    check("t6_still_arm", STATE, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
